// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: SPI pins and the received-word valid/ready port of spi_slave_rx.
interface spi_slave_rx_if #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 5
);
   logic              spi_CS;
   logic              spi_sclk;
   logic              spiData;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              frame_err;
   logic              overrun;
   logic [CNT_W-1:0]  bit_count;
   modport slave (
      input  spi_CS, spi_sclk, spiData, rx_ready,
      output rx_data, rx_valid, frame_err, overrun, bit_count
   );
   modport master (
      output spi_CS, spi_sclk, spiData, rx_ready,
      input  rx_data, rx_valid, frame_err, overrun, bit_count
   );
endinterface

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled SPI receive deserializer with valid/ready output, frame-error and overrun flags.
// Define SPI_RX_SYNC_EN to add a second flop per input for an asynchronous master (+1 cycle latency).
module spi_slave_rx #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 5
) (
   input logic clk,
   input logic reset,
   spi_slave_rx_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE, XTRA} state_e;
   state_e            state_q, state_d;
   logic              cs_in, sclk_in, dat_in;
   logic              cs_q, sclk_q, dat_q, cs_p_q, sclk_p_q;
   logic              cs_rise, cs_fall, sclk_rise, complete;
   logic [DATA_W-1:0] shreg_q, shreg_d, shreg_next, rx_data_q, rx_data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rx_valid_q, rx_valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
`ifdef SPI_RX_SYNC_EN
   logic cs_m_q, sclk_m_q, dat_m_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_m_q   <= 1'b1;
         sclk_m_q <= 1'b0;
         dat_m_q  <= 1'b0;
      end else begin
         cs_m_q   <= bus.spi_CS;
         sclk_m_q <= bus.spi_sclk;
         dat_m_q  <= bus.spiData;
      end
   end
   assign cs_in   = cs_m_q;
   assign sclk_in = sclk_m_q;
   assign dat_in  = dat_m_q;
`else
   assign cs_in   = bus.spi_CS;
   assign sclk_in = bus.spi_sclk;
   assign dat_in  = bus.spiData;
`endif
   assign cs_rise    = cs_q & ~cs_p_q;
   assign cs_fall    = ~cs_q & cs_p_q;
   assign sclk_rise  = sclk_q & ~sclk_p_q;
   assign shreg_next = {shreg_q[DATA_W-2:0], dat_q};
   // CS rise is tested before sclk rise so a coincident edge is ignored
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      ferr_d   = 1'b0;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               state_d = IDLE;
               ferr_d  = 1'b1;
               cnt_d   = '0;
            end else if (sclk_rise) begin
               shreg_d = shreg_next;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  complete = 1'b1;
                  state_d  = DONE;
               end
            end
         end
         DONE, XTRA: begin
            if (cs_rise) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (sclk_rise && state_q == DONE) begin
               ferr_d  = 1'b1;
               state_d = XTRA;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // a completion in the same cycle as a handshake refills the register without a gap
   always_comb begin
      rx_valid_d = complete ? 1'b1 : (rx_valid_q & ~bus.rx_ready);
      rx_data_d  = (complete & (~rx_valid_q | bus.rx_ready)) ? shreg_next : rx_data_q;
      ovr_d      = complete & rx_valid_q & ~bus.rx_ready;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cs_q       <= 1'b1;
         sclk_q     <= 1'b0;
         dat_q      <= 1'b0;
         cs_p_q     <= 1'b1;
         sclk_p_q   <= 1'b0;
         shreg_q    <= '0;
         cnt_q      <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cs_q       <= cs_in;
         sclk_q     <= sclk_in;
         dat_q      <= dat_in;
         cs_p_q     <= cs_q;
         sclk_p_q   <= sclk_q;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
      end
   end
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.overrun   = ovr_q;
   assign bus.bit_count = cnt_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: table vectors, directed corner sequences and random frames checked against a frame-level model.
module tb_spi_slave_rx;
`ifdef SPI_RX_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif
   typedef struct {
      logic [15:0] w;
      int          n;
      int          words;
      int          errs;
      logic [15:0] last;
   } vec_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic man_ready = 1'b0;
   logic rnd = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   logic [15:0] got[$];
   int err_cnt = 0, ovr_cnt = 0, vcyc = 0, ncyc = 0;
   always #5 clk = ~clk;
   spi_slave_rx_if #(.DATA_W(16), .CNT_W(5)) bus ();
   spi_slave_rx #(.DATA_W(16), .CNT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
   assign bus.rx_ready = man_ready;
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.rx_valid && bus.rx_ready) got.push_back(bus.rx_data);
         if (bus.frame_err) err_cnt++;
         if (bus.overrun) ovr_cnt++;
         if (bus.rx_valid) vcyc++;
         ncyc++;
      end
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd) man_ready = 1'($urandom_range(0, 1));
   endtask
   task automatic cs_low();
      tick();
      bus.spi_CS = 1'b0;
   endtask
   task automatic bits(input logic [15:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         bus.spi_sclk = 1'b0;
         bus.spiData  = (i < 16) ? w[15-i] : 1'($urandom_range(0, 1));
         tick();
         bus.spi_sclk = 1'b1;
      end
   endtask
   task automatic cs_high();
      tick();
      bus.spi_sclk = 1'b0;
      tick();
      bus.spi_CS = 1'b1;
   endtask
   task automatic frame(input logic [15:0] w, input int n);
      cs_low();
      bits(w, n);
      cs_high();
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   initial begin
      vec_t tbl[6];
      logic [15:0] exp_q[$];
      int g, e, v, o, nc, n, exp_err;
      tbl[0] = '{16'hA5C3, 16, 1, 0, 16'hA5C3};
      tbl[1] = '{16'h1357, 7, 0, 1, 16'h0000};
      tbl[2] = '{16'h00FF, 16, 1, 0, 16'h00FF};
      tbl[3] = '{16'hBEEF, 17, 1, 1, 16'hBEEF};
      tbl[4] = '{16'h0000, 16, 1, 0, 16'h0000};
      tbl[5] = '{16'h8000, 15, 0, 1, 16'h0000};
      bus.spi_CS = 1'b1;
      bus.spi_sclk = 1'b0;
      bus.spiData = 1'b0;
      repeat (3) tick();
      chk("reset rx_valid", 32'(bus.rx_valid), 0);
      chk("reset rx_data", 32'(bus.rx_data), 0);
      chk("reset frame_err", 32'(bus.frame_err), 0);
      chk("reset overrun", 32'(bus.overrun), 0);
      chk("reset bit_count", 32'(bus.bit_count), 0);
      reset = 1'b0;
      tick();
      man_ready = 1'b1;
      foreach (tbl[k]) begin
         g = got.size(); e = err_cnt; v = vcyc; o = ovr_cnt;
         frame(tbl[k].w, tbl[k].n);
         repeat (5) tick();
         chk($sformatf("vec%0d words", k), 32'(got.size() - g), 32'(tbl[k].words));
         chk($sformatf("vec%0d frame_err", k), 32'(err_cnt - e), 32'(tbl[k].errs));
         chk($sformatf("vec%0d valid cycles", k), 32'(vcyc - v), 32'(tbl[k].words));
         chk($sformatf("vec%0d overrun", k), 32'(ovr_cnt - o), 0);
         if (tbl[k].words > 0) chk($sformatf("vec%0d data", k), 32'(got[$]), 32'(tbl[k].last));
      end
      // back-to-back frames with the consumer stalled
      man_ready = 1'b0;
      g = got.size(); o = ovr_cnt;
      frame(16'h1234, 16);
      frame(16'hFFFF, 16);
      repeat (3) tick();
      chk("stall rx_valid", 32'(bus.rx_valid), 1);
      chk("stall rx_data", 32'(bus.rx_data), 32'h1234);
      chk("stall overrun", 32'(ovr_cnt - o), 1);
      man_ready = 1'b1;
      tick(); tick();
      man_ready = 1'b0;
      chk("stall drain words", 32'(got.size() - g), 1);
      chk("stall drain data", 32'(got[$]), 32'h1234);
      chk("stall drain rx_valid", 32'(bus.rx_valid), 0);
      // reset in the middle of a frame while a word is held
      frame(16'h7E7E, 16);
      cs_low();
      bits(16'hC3C3, 9);
      tick();
      reset = 1'b1;
      bus.spi_CS = 1'b1;
      bus.spi_sclk = 1'b0;
      tick();
      reset = 1'b0;
      chk("midreset rx_valid", 32'(bus.rx_valid), 0);
      chk("midreset rx_data", 32'(bus.rx_data), 0);
      chk("midreset frame_err", 32'(bus.frame_err), 0);
      chk("midreset overrun", 32'(bus.overrun), 0);
      chk("midreset bit_count", 32'(bus.bit_count), 0);
      tick();
      frame(16'h8001, 16);
      repeat (3) tick();
      chk("postreset rx_data", 32'(bus.rx_data), 32'h8001);
      chk("postreset rx_valid", 32'(bus.rx_valid), 1);
      man_ready = 1'b1;
      tick(); tick();
      man_ready = 1'b0;
      // latency from the last sclk rise at the pin to rx_valid
      cs_low();
      bits(16'h5A5A, 16);
      n = 0;
      for (int t = 0; t < 8; t++) begin
         tick();
         n++;
         if (bus.rx_valid) break;
      end
      chk("latency", 32'(n), 32'(LAT));
      cs_high();
      chk("latency rx_data", 32'(bus.rx_data), 32'h5A5A);
      man_ready = 1'b1;
      tick(); tick();
      man_ready = 1'b0;
      // ready exactly in the cycle the second word completes
      frame(16'h0F0F, 16);
      cs_low();
      bits(16'hF0F0, 16);
      g = got.size(); o = ovr_cnt; v = vcyc; nc = ncyc;
      repeat (LAT - 1) tick();
      man_ready = 1'b1;
      tick();
      man_ready = 1'b0;
      cs_high();
      tick(); tick();
      chk("handoff accepted", 32'(got.size() - g), 1);
      chk("handoff old word", 32'(got[$]), 32'h0F0F);
      chk("handoff overrun", 32'(ovr_cnt - o), 0);
      chk("handoff rx_data", 32'(bus.rx_data), 32'hF0F0);
      chk("handoff no gap", 32'(vcyc - v), 32'(ncyc - nc));
      man_ready = 1'b1;
      tick(); tick();
      chk("handoff drain", 32'(got[$]), 32'hF0F0);
      // random frames: full, aborted short, or with extra sclk edges
      g = got.size(); e = err_cnt; o = ovr_cnt; exp_err = 0;
      rnd = 1'b1;
      for (int f = 0; f < 40; f++) begin
         logic [15:0] w;
         int kind, nb;
         kind = $urandom_range(0, 2);
         w = 16'($urandom);
         nb = (kind == 0) ? 16 : (kind == 1) ? $urandom_range(1, 15) : $urandom_range(17, 19);
         if (nb >= 16) exp_q.push_back(w);
         if (nb != 16) exp_err++;
         frame(w, nb);
         rnd = 1'b0;
         man_ready = 1'b1;
         repeat (5) tick();
         rnd = 1'b1;
      end
      rnd = 1'b0;
      chk("random word count", 32'(got.size() - g), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && g + i < got.size(); i++)
         chk($sformatf("random word %0d", i), 32'(got[g+i]), 32'(exp_q[i]));
      chk("random frame_err", 32'(err_cnt - e), 32'(exp_err));
      chk("random overrun", 32'(ovr_cnt - o), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
